// File: rtl/lc3b_types.sv
// Shared types and constants for the LC-3b data-memory responder.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned DMEM_ADDR_WIDTH      = 16;
  localparam int unsigned DMEM_DATA_WIDTH      = 16;
  localparam int unsigned DMEM_WD_WIDTH        = 16;

  // Physical memory is word addressed; the byte-select bit is dropped.
  function automatic logic [DMEM_ADDR_WIDTH-1:0] word_align(input logic [DMEM_ADDR_WIDTH-1:0] a);
    return {a[DMEM_ADDR_WIDTH-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Access watchdog: counts cycles spent waiting on physical memory and
// flags the last permitted cycle.
module dmem_watchdog
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  logic [DMEM_WD_WIDTH-1:0] count;

  assign terminal_c = (count == DMEM_WD_WIDTH'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal value so a stalled enable cannot wrap around.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal_c) begin
      count <= count + DMEM_WD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: bridges level-held pipeline requests to a
// variable-latency physical memory and returns a one-cycle completion pulse.
module dmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [DMEM_ADDR_WIDTH-1:0] mem_address,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [1:0]                 mem_byte_enable,
  input  logic                       advance,
  input  logic                       second_cycle_request,
  output logic                       data_response,
  output logic [DMEM_DATA_WIDTH-1:0] mem_rdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [DMEM_ADDR_WIDTH-1:0] pmem_address,
  output logic [DMEM_DATA_WIDTH-1:0] pmem_wdata,
  output logic [1:0]                 pmem_byte_enable,
  input  logic                       pmem_resp,
  input  logic [DMEM_DATA_WIDTH-1:0] pmem_rdata,
  output logic                       mem_error,
  output logic [COUNT_WIDTH-1:0]     access_count
);

  dmem_state_t state;
  logic        armed;
  logic        scr_q;
  logic        wd_terminal_c;
  logic        arm_set_c;
  logic        accept_c;
  logic        finish_c;

  // A request seen alongside advance belongs to the retiring instruction.
  assign arm_set_c = advance | (second_cycle_request & ~scr_q);
  assign accept_c  = (state == IDLE) & armed & ~advance & (mem_read | mem_write);
  assign finish_c  = (state == ACCESS) & (pmem_resp | wd_terminal_c);

  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state != ACCESS),
    .enable    (state == ACCESS),
    .terminal_c(wd_terminal_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      armed            <= 1'b1;
      scr_q            <= 1'b0;
      data_response    <= 1'b0;
      mem_rdata        <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
      mem_error        <= 1'b0;
      access_count     <= '0;
    end else begin
      data_response <= 1'b0;
      scr_q         <= second_cycle_request;

      case (state)
        IDLE: begin
          if (accept_c) begin
            pmem_address     <= word_align(mem_address);
            pmem_wdata       <= mem_wdata;
            pmem_byte_enable <= mem_write ? mem_byte_enable : 2'b11;
            pmem_write       <= mem_write;
            pmem_read        <= mem_read & ~mem_write;
            if (mem_read && mem_write) begin
              mem_error <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (finish_c) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            // A real response beats a coincident timeout.
            if (pmem_resp) begin
              if (pmem_read) begin
                mem_rdata <= pmem_rdata;
              end
            end else begin
              mem_rdata <= '0;
              mem_error <= 1'b1;
            end
            data_response <= 1'b1;
            access_count  <= access_count + COUNT_WIDTH'(1);
            armed         <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (arm_set_c) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;
  import lc3b_types::*;

  logic        clk;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        advance;
  logic        second_cycle_request;
  logic        data_response;
  logic [15:0] mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;
  logic        mem_error;
  logic [15:0] access_count;

  int tests_run;
  int tests_failed;
  int strobes_seen;

  dmem_responder #(
    .TIMEOUT_CYCLES(4),
    .COUNT_WIDTH   (16)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_address         (mem_address),
    .mem_wdata           (mem_wdata),
    .mem_byte_enable     (mem_byte_enable),
    .advance             (advance),
    .second_cycle_request(second_cycle_request),
    .data_response       (data_response),
    .mem_rdata           (mem_rdata),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_byte_enable    (pmem_byte_enable),
    .pmem_resp           (pmem_resp),
    .pmem_rdata          (pmem_rdata),
    .mem_error           (mem_error),
    .access_count        (access_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_advance();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  initial begin
    tests_run            = 0;
    tests_failed         = 0;
    reset_n              = 1'b0;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    mem_address          = '0;
    mem_wdata            = '0;
    mem_byte_enable      = '0;
    advance              = 1'b0;
    second_cycle_request = 1'b0;
    pmem_resp            = 1'b0;
    pmem_rdata           = '0;

    // Reset values
    tick();
    tick();
    check("rst_resp",  32'(data_response), 32'd0);
    check("rst_pread", 32'(pmem_read), 32'd0);
    check("rst_pwr",   32'(pmem_write), 32'd0);
    check("rst_paddr", 32'(pmem_address), 32'h0);
    check("rst_rdata", 32'(mem_rdata), 32'h0);
    check("rst_err",   32'(mem_error), 32'd0);
    check("rst_cnt",   32'(access_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Read 0x3001, pmem_resp in cycle 3
    mem_read    = 1'b1;
    mem_address = 16'h3001;
    tick();
    check("rd_pread", 32'(pmem_read), 32'd1);
    check("rd_paddr", 32'(pmem_address), 32'h3000);
    check("rd_pbe",   32'(pmem_byte_enable), 32'h3);
    tick();
    tick();
    check("rd_noresp_c3", 32'(data_response), 32'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hBEEF;
    tick();
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    check("rd_resp",  32'(data_response), 32'd1);
    check("rd_rdata", 32'(mem_rdata), 32'hBEEF);
    check("rd_cnt",   32'(access_count), 32'd1);
    check("rd_drop",  32'(pmem_read), 32'd0);
    tick();
    check("rd_pulse1", 32'(data_response), 32'd0);

    // Byte write to 0x0102, pmem_resp in cycle 1
    pulse_advance();
    mem_write       = 1'b1;
    mem_address     = 16'h0102;
    mem_wdata       = 16'h00A5;
    mem_byte_enable = 2'b01;
    tick();
    check("wr_pwr",   32'(pmem_write), 32'd1);
    check("wr_pread", 32'(pmem_read), 32'd0);
    check("wr_paddr", 32'(pmem_address), 32'h0102);
    check("wr_pbe",   32'(pmem_byte_enable), 32'h1);
    check("wr_wdata", 32'(pmem_wdata), 32'h00A5);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    mem_write = 1'b0;
    check("wr_resp",  32'(data_response), 32'd1);
    check("wr_rdata", 32'(mem_rdata), 32'hBEEF);
    check("wr_cnt",   32'(access_count), 32'd2);

    // Held read is serviced once; second_cycle_request re-arms
    pulse_advance();
    mem_read    = 1'b1;
    mem_address = 16'h2000;
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 16'h1234;
    tick();
    pmem_resp = 1'b0;
    check("held_resp", 32'(data_response), 32'd1);
    strobes_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pmem_read || pmem_write) strobes_seen++;
    end
    check("held_nostrobe", 32'(strobes_seen), 32'd0);
    mem_address          = 16'h4000;
    second_cycle_request = 1'b1;
    tick();
    check("scr_notyet", 32'(pmem_read), 32'd0);
    tick();
    check("scr_pread", 32'(pmem_read), 32'd1);
    check("scr_paddr", 32'(pmem_address), 32'h4000);
    second_cycle_request = 1'b0;
    pmem_resp            = 1'b1;
    pmem_rdata           = 16'h5678;
    tick();
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    check("scr_rdata", 32'(mem_rdata), 32'h5678);
    check("scr_cnt",   32'(access_count), 32'd4);

    // pmem_resp on the terminal watchdog cycle wins over timeout
    pulse_advance();
    mem_read    = 1'b1;
    mem_address = 16'h0020;
    tick();
    mem_read = 1'b0;
    tick();
    tick();
    tick();
    check("coin_noresp_c4", 32'(data_response), 32'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'h0ACE;
    tick();
    pmem_resp = 1'b0;
    check("coin_resp",  32'(data_response), 32'd1);
    check("coin_rdata", 32'(mem_rdata), 32'h0ACE);
    check("coin_err",   32'(mem_error), 32'd0);
    check("coin_cnt",   32'(access_count), 32'd5);
    tick();

    // Request coincident with advance is not accepted
    advance     = 1'b1;
    mem_read    = 1'b1;
    mem_address = 16'h0040;
    tick();
    advance  = 1'b0;
    mem_read = 1'b0;
    check("adv_noacc", 32'(pmem_read), 32'd0);
    tick();
    check("adv_noacc2", 32'(pmem_read), 32'd0);

    // Timeout: no pmem_resp; the request also drops mid-access
    mem_read    = 1'b1;
    mem_address = 16'h0010;
    tick();
    mem_read = 1'b0;
    check("to_pread", 32'(pmem_read), 32'd1);
    tick();
    tick();
    tick();
    check("to_noresp_c4", 32'(data_response), 32'd0);
    tick();
    check("to_resp",  32'(data_response), 32'd1);
    check("to_rdata", 32'(mem_rdata), 32'h0);
    check("to_err",   32'(mem_error), 32'd1);
    check("to_cnt",   32'(access_count), 32'd6);
    check("to_drop",  32'(pmem_read), 32'd0);
    tick();
    tick();
    tick();
    check("to_sticky", 32'(mem_error), 32'd1);

    // Reset mid-access; a late pmem_resp is ignored
    pulse_advance();
    mem_read    = 1'b1;
    mem_address = 16'h0030;
    tick();
    mem_read = 1'b0;
    check("mid_pread", 32'(pmem_read), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_pread0", 32'(pmem_read), 32'd0);
    check("mid_paddr0", 32'(pmem_address), 32'h0);
    check("mid_err0",   32'(mem_error), 32'd0);
    check("mid_cnt0",   32'(access_count), 32'd0);
    check("mid_rdata0", 32'(mem_rdata), 32'h0);
    reset_n   = 1'b1;
    pmem_resp = 1'b1;
    tick();
    check("late_noresp1", 32'(data_response), 32'd0);
    tick();
    pmem_resp = 1'b0;
    check("late_noresp2", 32'(data_response), 32'd0);
    check("late_cnt",     32'(access_count), 32'd0);

    // Illegal read+write: serviced as a write and flagged
    mem_read        = 1'b1;
    mem_write       = 1'b1;
    mem_address     = 16'h0051;
    mem_wdata       = 16'h1111;
    mem_byte_enable = 2'b10;
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("ill_pwr",   32'(pmem_write), 32'd1);
    check("ill_pread", 32'(pmem_read), 32'd0);
    check("ill_paddr", 32'(pmem_address), 32'h0050);
    check("ill_pbe",   32'(pmem_byte_enable), 32'h2);
    check("ill_err",   32'(mem_error), 32'd1);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("ill_resp", 32'(data_response), 32'd1);
    check("ill_cnt",  32'(access_count), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory handshake. The MEM/WB stage drives a level-held mem_read/mem_write request with address and wdata; this block answers with a one-cycle data_response.
- Bridges requests to a variable-latency physical data memory (pmem_*).
- Re-arms only on pipeline advance or a second-cycle (LDI/STI indirect) request, so a held request is never serviced twice.
- Adds a timeout watchdog, a sticky error flag and an access counter.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS before a forced error response (1..65535).
- COUNT_WIDTH, 16: width of access_count.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  synchronous active-low reset
- mem_read  in  1  read request from the MEM stage, level-held
- mem_write  in  1  write request from the MEM stage, level-held
- mem_address  in  16  byte address
- mem_wdata  in  16  store data
- mem_byte_enable  in  2  byte lanes for a write
- advance  in  1  pipeline advance strobe
- second_cycle_request  in  1  indirect second-access request from MEM/WB
- data_response  out  1  one-cycle completion pulse
- mem_rdata  out  16  read data, held until the next response
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_address  out  16  word-aligned address
- pmem_wdata  out  16  physical write data
- pmem_byte_enable  out  2  physical byte lanes
- pmem_resp  in  1  physical access complete
- pmem_rdata  in  16  physical read data
- mem_error  out  1  sticky error flag
- access_count  out  COUNT_WIDTH  completed-response counter

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous active-low.
  - Reset values: state=IDLE, armed=1, all pmem_* outputs 0, data_response=0, mem_rdata=0, mem_error=0, access_count=0, watchdog=0, scr_q=0.
- Registered outputs: every output is registered.
- State machine: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when armed & (mem_read | mem_write).
  - On accept, latch into pmem_*:
    - address = {mem_address[15:1], 0}
    - pmem_wdata = mem_wdata
    - pmem_byte_enable = mem_byte_enable on a write, 2'b11 on a read
  - Assert pmem_read or pmem_write from the next cycle; watchdog=0; go to ACCESS.
- Illegal request: mem_read & mem_write together is serviced as a write and sets mem_error.
- ACCESS:
  - Hold all pmem_* outputs stable; watchdog increments each cycle.
  - On pmem_resp:
    - Drop the strobes.
    - For a read, capture mem_rdata = pmem_rdata (for a write, mem_rdata is unchanged).
    - Pulse data_response next cycle; clear armed; access_count += 1 (wraps modulo 2^COUNT_WIDTH); go to DONE.
  - On timeout (watchdog reaches TIMEOUT_CYCLES-1 without pmem_resp): same as pmem_resp, except mem_rdata=0 and mem_error=1.
  - pmem_resp and timeout in the same cycle: pmem_resp wins, no error.
- DONE:
  - data_response=1 for exactly this cycle, then IDLE.
  - Requests are never accepted in DONE.
- Latency: request visible in cycle 0 → strobes in cycle 1 → pmem_resp in cycle n (n≥1) → data_response in cycle n+1. Minimum is 2 cycles.
- Re-arm:
  - armed sets on advance=1, or on a rising edge of second_cycle_request (scr_q registers the previous value).
  - Re-arm takes effect from the following cycle. A request present in the same cycle as advance belongs to the retiring instruction and is not accepted.
  - advance during ACCESS or DONE: armed still sets; the in-flight access completes normally.
- Request drop: mem_read/mem_write dropping during ACCESS does not abort the access; the response is still issued.
- Reset mid-access: strobes drop at the reset edge; pmem_resp arriving afterwards is ignored in IDLE.
- pmem_resp in IDLE or DONE: ignored, no error.

Decomposition:
- Package lc3b_types gains:
  - enum dmem_state_t {IDLE, ACCESS, DONE}
  - constant DMEM_TIMEOUT_DEFAULT = 255
- Sub-module dmem_watchdog: counter with clear/enable and a terminal-count output (TIMEOUT_CYCLES parameter), instantiated once.

Test Plan:
- Read, reset released, armed: mem_read=1, addr 16'h3001; pmem_resp after 3 cycles with 16'hBEEF → pmem_address 16'h3000, data_response pulse in cycle 4, mem_rdata 16'hBEEF, access_count 1.
- Write byte, addr 16'h0102, wdata 16'h00A5, byte_enable 2'b01; pmem_resp in cycle 1 → pmem_write=1, pmem_byte_enable 2'b01, data_response in cycle 2, mem_rdata unchanged.
- Held request without advance: mem_read stays 1 for 10 cycles after the response → no second pmem_read. Then pulse second_cycle_request with a new addr 16'h4000 → one new access to 16'h4000.
- Timeout: TIMEOUT_CYCLES=4, pmem_resp never asserted → data_response in cycle 5, mem_rdata 0, mem_error 1 and stays 1 until reset.
- Coincidence: pmem_resp on the terminal watchdog cycle → normal response, mem_error stays 0. advance with a request in the same cycle → that request is not accepted.
- Reset mid-access: reset_n=0 during ACCESS → strobes 0 at the next edge, all outputs at reset values; a late pmem_resp produces no data_response.
